// File: rtl/mult_accum.sv
// Dot-product accumulator behind the MULT core with a 2-deep result FIFO.
// Define MULT_ACCUM_SATURATE_EN for saturating arithmetic and a sticky sat flag.
module mult_accum #(
  parameter int MULT_LAT = 3,
  parameter int P_W      = 32,
  parameter int ACC_W    = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ab_valid,
  input  logic                    ab_last,
  input  logic signed [P_W-1:0]   p,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    sat,
  output logic                    idle
);

  logic [MULT_LAT-1:0] v_sr;
  logic [MULT_LAT-1:0] l_sr;
  logic v_al;
  logic l_al;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] pext;
  logic signed [ACC_W-1:0] raw;
  logic signed [ACC_W-1:0] sum;
  logic first;
  logic ovf;

  logic signed [ACC_W-1:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;
  logic       full;
  logic       do_push;

  // Issue strobes ride a chain matching the multiplier latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= ab_valid;
      l_sr[0] <= ab_valid & ab_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        v_sr[i] <= v_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign v_al = v_sr[MULT_LAT-1];
  assign l_al = l_sr[MULT_LAT-1] & v_al;

  // Next accumulator value: fresh start on first term, wrap or clamp.
  always_comb begin
    base = first ? '0 : acc;
    pext = {{(ACC_W-P_W){p[P_W-1]}}, p};
    raw  = base + pext;
    ovf  = (base[ACC_W-1] == pext[ACC_W-1]) &&
           (raw[ACC_W-1] != base[ACC_W-1]);
    sum  = raw;
`ifdef MULT_ACCUM_SATURATE_EN
    if (ovf) begin
      sum = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                          : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // Accumulator and group-start flag advance on each aligned term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (v_al) begin
      acc   <= sum;
      first <= l_al;
    end
  end

`ifdef MULT_ACCUM_SATURATE_EN
  // Sticky record of any clamped accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat <= 1'b0;
    else if (v_al && ovf) sat <= 1'b1;
  end
`else
  assign sat = 1'b0;
`endif

  assign push    = l_al;
  assign pop     = out_valid & out_ready;
  assign full    = (cnt == 2'd2);
  assign do_push = push & (~full | pop);

  // Result FIFO; a push into a full FIFO without a pop is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      cnt     <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= sum;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({do_push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign idle      = ~|v_sr & first & (cnt == 2'd0);

endmodule
